fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage MIPS core; directly upstream of the control decoder.
- Holds the PC and presents it to instruction memory (combinational read).
- Latches the fetched word and splits it into opCode/funct/rs/rt for ID.
- Implements load-use stall detection, branch/jump/illegal-op redirect and IF/ID flush, and captures EPC.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: PC, instruction latch, load-use stall,
// branch/jump/exception redirect with IF/ID flush, EPC capture and stall counter.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        id_ex_MemRead,
  input  logic [4:0]  id_ex_rt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [1:0]  Jump,
  input  logic [31:0] jr_target,
  input  logic        illOp,
  output logic [5:0]  opCode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        stall,
  output logic        flush_id_ex,
  output logic [31:0] epc,
  output logic [15:0] stall_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  pc, pc_plus4;
  logic [XLEN-1:0]  pc_d, instr_d, pc4_d, epc_d;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_d;
  logic             uses_rs, uses_rt, hazard, exc_take;

  assign pc_out   = pc;
  assign pc_plus4 = pc + XLEN'(4);

  assign opCode = if_id_instr[31:26];
  assign funct  = if_id_instr[5:0];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];

  // Which source register fields the ID-stage instruction actually reads
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opCode)
      6'b000000, 6'b000100, 6'b000101, 6'b101011: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011: uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign hazard = if_id_valid & id_ex_MemRead & (id_ex_rt != 5'd0) &
                  ((uses_rs & (rs == id_ex_rt)) | (uses_rt & (rt == id_ex_rt)));
  assign exc_take = illOp & if_id_valid;

  assign stall       = reset & hazard & ~branch_taken & ~exc_take;
  assign flush_id_ex = reset & branch_taken;

  // Next-state selection in redirect priority order
  always_comb begin
    pc_d    = pc_plus4;
    instr_d = instr_in;
    pc4_d   = pc_plus4;
    valid_d = 1'b1;
    epc_d   = epc;
    cnt_d   = stall_count;
    if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (exc_take) begin
      pc_d    = EXC_VECTOR;
      epc_d   = if_id_pc4 - XLEN'(4);
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (hazard) begin
      pc_d    = pc;
      instr_d = if_id_instr;
      pc4_d   = if_id_pc4;
      valid_d = if_id_valid;
      if (stall_count != CNT_MAX) cnt_d = stall_count + CNT_W'(1);
    end else if (Jump == 2'b01 && if_id_valid) begin
      pc_d    = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (Jump == 2'b10 && if_id_valid) begin
      pc_d    = jr_target;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_VECTOR;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      epc         <= '0;
      stall_count <= '0;
    end else begin
      pc          <= pc_d;
      if_id_instr <= instr_d;
      if_id_pc4   <= pc4_d;
      if_id_valid <= valid_d;
      epc         <= epc_d;
      stall_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected post-edge state is queued with each
// stimulus step and compared after the clock edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out, instr_in, branch_target, jr_target;
  logic        id_ex_MemRead, branch_taken, illOp;
  logic [4:0]  id_ex_rt;
  logic [1:0]  Jump;
  logic [5:0]  opCode, funct;
  logic [4:0]  rs, rt;
  logic [31:0] if_id_instr, if_id_pc4, epc;
  logic        if_id_valid, stall, flush_id_ex;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc, instr, pc4;
    logic        valid;
    logic [31:0] epc;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .instr_in(instr_in),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .Jump(Jump), .jr_target(jr_target), .illOp(illOp),
    .opCode(opCode), .funct(funct), .rs(rs), .rt(rt),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .stall(stall), .flush_id_ex(flush_id_ex), .epc(epc), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid, input logic [31:0] e,
                          input logic [15:0] cnt);
    exp_t x;
    x.tag = tag; x.pc = pc; x.instr = instr; x.pc4 = pc4;
    x.valid = valid; x.epc = e; x.cnt = cnt;
    exp_q.push_back(x);
  endtask

  // Clock one edge, compare the oldest queued expectation, return at the next falling edge
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check({x.tag, ".pc"},    pc_out,                x.pc);
      check({x.tag, ".instr"}, if_id_instr,           x.instr);
      check({x.tag, ".pc4"},   if_id_pc4,             x.pc4);
      check({x.tag, ".valid"}, 32'(if_id_valid),      32'(x.valid));
      check({x.tag, ".epc"},   epc,                   x.epc);
      check({x.tag, ".cnt"},   32'(stall_count),      32'(x.cnt));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"},    pc_out,                32'h0);
    check({tag, ".instr"}, if_id_instr,           32'h0);
    check({tag, ".pc4"},   if_id_pc4,             32'h0);
    check({tag, ".valid"}, 32'(if_id_valid),      32'h0);
    check({tag, ".epc"},   epc,                   32'h0);
    check({tag, ".cnt"},   32'(stall_count),      32'h0);
    check({tag, ".stall"}, 32'(stall),            32'h0);
    check({tag, ".flush"}, 32'(flush_id_ex),      32'h0);
  endtask

  initial begin
    reset = 1'b0; instr_in = 32'h0; id_ex_MemRead = 1'b0; id_ex_rt = 5'd0;
    branch_taken = 1'b1; branch_target = 32'h0000_0100; Jump = 2'b00;
    jr_target = 32'h0; illOp = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);

    reset = 1'b1; branch_taken = 1'b0; instr_in = 32'h2008_0005;
    #1 check("first_pc", pc_out, 32'h0);
    push_exp("fetch1", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 32'h0, 16'd0);
    tick();
    check("fetch1.opCode", 32'(opCode), 32'h08);
    check("fetch1.rt",     32'(rt),     32'h08);
    check("fetch1.rs",     32'(rs),     32'h00);

    instr_in = 32'h0044_1820;
    push_exp("fetch2", 32'h8, 32'h0044_1820, 32'h8, 1'b1, 32'h0, 16'd0);
    tick();
    check("add.funct", 32'(funct), 32'h20);
    check("add.rs",    32'(rs),    32'h02);
    check("add.rt",    32'(rt),    32'h04);

    // load-use on rs, then rt-only match, then $0 never stalls
    id_ex_MemRead = 1'b1; id_ex_rt = 5'd2; instr_in = 32'hDEAD_BEEF;
    #1 check("hazard_rs.stall", 32'(stall), 32'h1);
    check("hazard_rs.flush", 32'(flush_id_ex), 32'h0);
    push_exp("stall1", 32'h8, 32'h0044_1820, 32'h8, 1'b1, 32'h0, 16'd1);
    tick();
    id_ex_rt = 5'd0;
    #1 check("rt_zero.stall", 32'(stall), 32'h0);
    id_ex_rt = 5'd4;
    #1 check("hazard_rt.stall", 32'(stall), 32'h1);
    id_ex_rt = 5'd0; Jump = 2'b11; instr_in = 32'h0044_1820;
    push_exp("jump11", 32'hC, 32'h0044_1820, 32'hC, 1'b1, 32'h0, 16'd1);
    tick();

    // branch wins over hazard, illegal op and jump
    Jump = 2'b01; id_ex_rt = 5'd2; illOp = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    #1 check("branch.flush", 32'(flush_id_ex), 32'h1);
    check("branch.stall", 32'(stall), 32'h0);
    push_exp("branch", 32'h100, 32'h0, 32'h0, 1'b0, 32'h0, 16'd1);
    tick();

    id_ex_MemRead = 1'b0; illOp = 1'b0; Jump = 2'b00; branch_target = 32'h1000_0004;
    push_exp("br_hi", 32'h1000_0004, 32'h0, 32'h0, 1'b0, 32'h0, 16'd1);
    tick();
    branch_taken = 1'b0; instr_in = 32'h0800_0040;
    push_exp("fetch_j", 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1'b1, 32'h0, 16'd1);
    tick();
    Jump = 2'b01;
    push_exp("j", 32'h1000_0100, 32'h0, 32'h0, 1'b0, 32'h0, 16'd1);
    tick();
    Jump = 2'b00; instr_in = 32'h03E0_0008;
    push_exp("fetch_jr", 32'h1000_0104, 32'h03E0_0008, 32'h1000_0104, 1'b1, 32'h0, 16'd1);
    tick();

    // jr deferred while its source is a pending load
    Jump = 2'b10; jr_target = 32'h44; id_ex_MemRead = 1'b1; id_ex_rt = 5'd31;
    #1 check("jr_hazard.stall", 32'(stall), 32'h1);
    push_exp("jr_wait", 32'h1000_0104, 32'h03E0_0008, 32'h1000_0104, 1'b1, 32'h0, 16'd2);
    tick();
    id_ex_MemRead = 1'b0;
    push_exp("jr", 32'h44, 32'h0, 32'h0, 1'b0, 32'h0, 16'd2);
    tick();

    Jump = 2'b00; branch_taken = 1'b1; branch_target = 32'h20;
    push_exp("br_20", 32'h20, 32'h0, 32'h0, 1'b0, 32'h0, 16'd2);
    tick();
    branch_taken = 1'b0; instr_in = 32'hFC00_0000;
    push_exp("fetch_ill", 32'h24, 32'hFC00_0000, 32'h24, 1'b1, 32'h0, 16'd2);
    tick();
    illOp = 1'b1;
    push_exp("illop", 32'h80, 32'h0, 32'h0, 1'b0, 32'h20, 16'd2);
    tick();

    illOp = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    push_exp("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'h20, 16'd2);
    tick();
    branch_taken = 1'b0; instr_in = 32'h0;
    push_exp("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 32'h20, 16'd2);
    tick();
    instr_in = 32'h0044_1820;
    push_exp("fetch_sat", 32'h4, 32'h0044_1820, 32'h4, 1'b1, 32'h20, 16'd2);
    tick();

    // long stall drives the counter into saturation
    id_ex_MemRead = 1'b1; id_ex_rt = 5'd2;
    #1 check("sat.stall", 32'(stall), 32'h1);
    repeat (69999) @(posedge clk);
    @(negedge clk);
    push_exp("saturate", 32'h4, 32'h0044_1820, 32'h4, 1'b1, 32'h20, 16'hFFFF);
    tick();

    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
